// File: rtl/time_set_arbiter.sv
// Purpose : arbitrates button/UART clock-set requests, range-checks hh:mm and drives a
//           registered load/min/h triple into the slow seconds/minutes/hours counter.
// Latency : request rising edge sampled at edge N -> pending at N -> gnt/load/busy at N+1.
// Backpr. : load is held until the counter's 1 Hz strobe is seen (or a timeout expires);
//           requests arriving meanwhile stay pending and are served one idle cycle later.
//
// Ports   : clk_MHz, rst (sync, active-high)
//           req_butoane/min_butoane/h_butoane : button request level + minute/hour value
//           req_uart/min_uart/h_uart          : UART request level + minute/hour value
//           tick_1hz                          : strobe coincident with the counter update edge
//           load/min_out/h_out                : registered load triple to the counter
//           gnt_butoane/gnt_uart/err_range    : one-cycle status pulses
//           busy                              : high while a load is being held
// Config  : define ARB_RR_EN for round-robin between simultaneous pending requests;
//           otherwise the button source has fixed priority over the UART.

module time_set_arbiter #(
    parameter int unsigned MAX_MIN      = 59,
    parameter int unsigned MAX_H        = 23,
    parameter int unsigned TICK_TIMEOUT = 100000000
) (
    input  logic       clk_MHz,
    input  logic       rst,
    input  logic       req_butoane,
    input  logic [5:0] min_butoane,
    input  logic [5:0] h_butoane,
    input  logic       req_uart,
    input  logic [5:0] min_uart,
    input  logic [5:0] h_uart,
    input  logic       tick_1hz,
    output logic       load,
    output logic [5:0] min_out,
    output logic [5:0] h_out,
    output logic       gnt_butoane,
    output logic       gnt_uart,
    output logic       err_range,
    output logic       busy
);

    // Timer counts cycles spent in LOAD; it only has to reach TICK_TIMEOUT-1.
    localparam int unsigned          TIMER_W    = (TICK_TIMEOUT > 1) ? $clog2(TICK_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(TICK_TIMEOUT - 1);
    localparam logic [5:0]           MAX_MIN_6  = 6'(MAX_MIN);
    localparam logic [5:0]           MAX_H_6    = 6'(MAX_H);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t             state;
    logic               req_b_d;
    logic               req_u_d;
    logic               pend_b;
    logic               pend_u;
    logic [TIMER_W-1:0] timer;
`ifdef ARB_RR_EN
    logic               rr_last;   // 0 = button granted last, 1 = UART granted last
`endif

    logic       edge_b;
    logic       edge_u;
    logic       pick_b;
    logic       pick_u;
    logic [5:0] sel_min;
    logic [5:0] sel_h;
    logic       sel_ok;

    // A held level never re-requests: only the 0->1 transition counts.
    assign edge_b = req_butoane & ~req_b_d;
    assign edge_u = req_uart    & ~req_u_d;

    // Grant selection is only meaningful in IDLE; in LOAD requests just accumulate.
    always_comb begin
        pick_b = 1'b0;
        pick_u = 1'b0;
        if (state == IDLE) begin
            if (pend_b && pend_u) begin
`ifdef ARB_RR_EN
                if (rr_last) begin
                    pick_b = 1'b1;
                end else begin
                    pick_u = 1'b1;
                end
`else
                pick_b = 1'b1;
`endif
            end else if (pend_b) begin
                pick_b = 1'b1;
            end else if (pend_u) begin
                pick_u = 1'b1;
            end
        end
    end

    // The value bus is captured live on the grant edge, not when the request arrived.
    always_comb begin
        sel_min = pick_u ? min_uart : min_butoane;
        sel_h   = pick_u ? h_uart   : h_butoane;
        sel_ok  = (sel_min <= MAX_MIN_6) && (sel_h <= MAX_H_6);
    end

    always_ff @(posedge clk_MHz) begin
        if (rst) begin
            state       <= IDLE;
            req_b_d     <= 1'b0;
            req_u_d     <= 1'b0;
            pend_b      <= 1'b0;
            pend_u      <= 1'b0;
            timer       <= '0;
            load        <= 1'b0;
            busy        <= 1'b0;
            min_out     <= 6'd0;
            h_out       <= 6'd0;
            gnt_butoane <= 1'b0;
            gnt_uart    <= 1'b0;
            err_range   <= 1'b0;
`ifdef ARB_RR_EN
            rr_last     <= 1'b0;
`endif
        end else begin
            req_b_d <= req_butoane;
            req_u_d <= req_uart;

            // A new edge on the grant edge of the same source starts a fresh request;
            // otherwise extra edges merge into the one already pending.
            pend_b <= (pend_b & ~pick_b) | edge_b;
            pend_u <= (pend_u & ~pick_u) | edge_u;

            gnt_butoane <= pick_b;
            gnt_uart    <= pick_u;
            err_range   <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick_b || pick_u) begin
`ifdef ARB_RR_EN
                        rr_last <= pick_u;
`endif
                        if (sel_ok) begin
                            min_out <= sel_min;
                            h_out   <= sel_h;
                            load    <= 1'b1;
                            busy    <= 1'b1;
                            timer   <= '0;
                            state   <= LOAD;
                        end else begin
                            // Out-of-range value is dropped; previous min_out/h_out stay.
                            err_range <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    timer <= timer + 1'b1;
                    // Tick wins over a coincident timeout: the counter did sample load.
                    if (tick_1hz) begin
                        load  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (timer == TIMER_LAST) begin
                        load      <= 1'b0;
                        busy      <= 1'b0;
                        err_range <= 1'b1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_arbiter.sv
// Purpose : directed scenarios plus randomized traffic against a transaction-level model.
// Latency : model predicts outputs one edge after the inputs it samples.
// Backpr. : bench drives levels and ticks freely; no flow control on the bench side.

module tb_time_set_arbiter;

    localparam int TT = 16;

    logic       clk_MHz = 1'b0;
    logic       rst = 1'b1;
    logic       req_butoane = 1'b0;
    logic [5:0] min_butoane = 6'd0;
    logic [5:0] h_butoane = 6'd0;
    logic       req_uart = 1'b0;
    logic [5:0] min_uart = 6'd0;
    logic [5:0] h_uart = 6'd0;
    logic       tick_1hz = 1'b0;
    logic       load;
    logic [5:0] min_out;
    logic [5:0] h_out;
    logic       gnt_butoane;
    logic       gnt_uart;
    logic       err_range;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_MHz = ~clk_MHz;

    time_set_arbiter #(
        .MAX_MIN(59),
        .MAX_H(23),
        .TICK_TIMEOUT(TT)
    ) dut (
        .clk_MHz(clk_MHz),
        .rst(rst),
        .req_butoane(req_butoane),
        .min_butoane(min_butoane),
        .h_butoane(h_butoane),
        .req_uart(req_uart),
        .min_uart(min_uart),
        .h_uart(h_uart),
        .tick_1hz(tick_1hz),
        .load(load),
        .min_out(min_out),
        .h_out(h_out),
        .gnt_butoane(gnt_butoane),
        .gnt_uart(gnt_uart),
        .err_range(err_range),
        .busy(busy)
    );

    // Reference model: a load episode starts on a grant of an in-range request and lasts
    // until the first tick seen after entry, or TT cycles without one.
    bit m_pb, m_pu, m_db, m_du, m_load, m_gb, m_gu, m_err, m_rr;
    int m_age, m_min, m_h;

    task automatic model_step();
        bit eb, eu, gb, gu;
        int vm, vh;
        if (rst) begin
            {m_pb, m_pu, m_db, m_du, m_load, m_gb, m_gu, m_err, m_rr} = '0;
            m_age = 0; m_min = 0; m_h = 0;
            return;
        end
        eb = req_butoane && !m_db;
        eu = req_uart && !m_du;
        gb = 0; gu = 0;
        m_gb = 0; m_gu = 0; m_err = 0;
        if (m_load) begin
            m_age++;
            if (tick_1hz) m_load = 0;
            else if (m_age == TT) begin m_load = 0; m_err = 1; end
        end else if (m_pb || m_pu) begin
            if (m_pb && m_pu) begin
`ifdef ARB_RR_EN
                gb = m_rr; gu = !m_rr;
`else
                gb = 1;
`endif
            end else begin
                gb = m_pb; gu = m_pu;
            end
            m_rr = gu;
            m_gb = gb; m_gu = gu;
            vm = gu ? int'(min_uart) : int'(min_butoane);
            vh = gu ? int'(h_uart) : int'(h_butoane);
            if (vm > 59 || vh > 23) m_err = 1;
            else begin m_load = 1; m_age = 0; m_min = vm; m_h = vh; end
        end
        m_pb = (m_pb && !gb) || eb;
        m_pu = (m_pu && !gu) || eu;
        m_db = req_butoane;
        m_du = req_uart;
    endtask

    task automatic cycle();
        @(posedge clk_MHz);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1; cycle(); cycle();
        n_checks++;
        if ({load, busy, gnt_butoane, gnt_uart, err_range, min_out, h_out} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 0",
                     {load, busy, gnt_butoane, gnt_uart, err_range, min_out, h_out});
        end
        rst = 0; cycle();
        n_checks++;
        if ({load, busy, gnt_butoane, gnt_uart, err_range} !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b expected 00000",
                     {load, busy, gnt_butoane, gnt_uart, err_range});
        end
    endtask

    task automatic test_button_load();
        min_butoane = 6'd30; h_butoane = 6'd12; req_butoane = 1;
        cycle();
        n_checks++;
        if ({load, busy, gnt_butoane, gnt_uart, err_range} !== 5'b00000) begin
            n_fail++;
            $display("FAIL btn_pend_cycle: got %b expected 00000", {load, busy, gnt_butoane, gnt_uart, err_range});
        end
        cycle();
        n_checks++;
        if ({load, busy, gnt_butoane, gnt_uart, err_range, min_out, h_out} !== {5'b11100, 6'd30, 6'd12}) begin
            n_fail++;
            $display("FAIL btn_grant: got %b/%0d/%0d expected 11100/30/12",
                     {load, busy, gnt_butoane, gnt_uart, err_range}, min_out, h_out);
        end
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if ({load, busy, gnt_butoane, gnt_uart, err_range} !== 5'b11000) begin
                n_fail++;
                $display("FAIL btn_hold_load[%0d]: got %b expected 11000", i, {load, busy, gnt_butoane, gnt_uart, err_range});
            end
        end
        tick_1hz = 1; cycle(); tick_1hz = 0;
        n_checks++;
        if ({load, busy, gnt_butoane, gnt_uart, err_range, min_out, h_out} !== {5'b00000, 6'd30, 6'd12}) begin
            n_fail++;
            $display("FAIL btn_tick_exit: got %b/%0d/%0d expected 00000/30/12",
                     {load, busy, gnt_butoane, gnt_uart, err_range}, min_out, h_out);
        end
        req_butoane = 0; cycle();
    endtask

    task automatic test_both();
        logic first_u;
`ifdef ARB_RR_EN
        first_u = !m_rr;
`else
        first_u = 1'b0;
`endif
        min_butoane = 6'd10; h_butoane = 6'd3; min_uart = 6'd20; h_uart = 6'd4;
        req_butoane = 1; req_uart = 1;
        cycle(); cycle();
        n_checks++;
        if ({load, gnt_butoane, gnt_uart, min_out} !== {1'b1, !first_u, first_u, first_u ? 6'd20 : 6'd10}) begin
            n_fail++;
            $display("FAIL both_first_grant: got l=%b gb=%b gu=%b min=%0d expected first_u=%b",
                     load, gnt_butoane, gnt_uart, min_out, first_u);
        end
        cycle(); cycle();
        tick_1hz = 1; cycle(); tick_1hz = 0;
        n_checks++;
        if ({load, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL both_gap_cycle: got load/busy %b expected 00", {load, busy});
        end
        cycle();
        n_checks++;
        if ({load, gnt_butoane, gnt_uart, min_out, h_out} !==
            {1'b1, first_u, !first_u, first_u ? 6'd10 : 6'd20, first_u ? 6'd3 : 6'd4}) begin
            n_fail++;
            $display("FAIL both_second_grant: got l=%b gb=%b gu=%b min=%0d h=%0d first_u=%b",
                     load, gnt_butoane, gnt_uart, min_out, h_out, first_u);
        end
        tick_1hz = 1; cycle(); tick_1hz = 0;
        req_butoane = 0; req_uart = 0; cycle();
    endtask

    task automatic test_range_err();
        int pm, ph;
        pm = m_min; ph = m_h;
        min_uart = 6'd60; h_uart = 6'd5; req_uart = 1;
        cycle(); cycle();
        n_checks++;
        if ({load, busy, gnt_butoane, gnt_uart, err_range, min_out, h_out} !== {5'b00011, 6'(pm), 6'(ph)}) begin
            n_fail++;
            $display("FAIL uart_min60: got %b/%0d/%0d expected 00011/%0d/%0d",
                     {load, busy, gnt_butoane, gnt_uart, err_range}, min_out, h_out, pm, ph);
        end
        cycle();
        n_checks++;
        if ({load, err_range, gnt_uart} !== 3'b000) begin
            n_fail++;
            $display("FAIL err_one_cycle: got %b expected 000", {load, err_range, gnt_uart});
        end
        req_uart = 0;
        min_butoane = 6'd0; h_butoane = 6'd24; req_butoane = 1;
        cycle(); cycle();
        n_checks++;
        if ({load, busy, gnt_butoane, gnt_uart, err_range} !== 5'b00101) begin
            n_fail++;
            $display("FAIL btn_h24: got %b expected 00101", {load, busy, gnt_butoane, gnt_uart, err_range});
        end
        req_butoane = 0; cycle();
        min_butoane = 6'd59; h_butoane = 6'd23; req_butoane = 1;
        cycle(); cycle();
        n_checks++;
        if ({load, busy, gnt_butoane, gnt_uart, err_range, min_out, h_out} !== {5'b11100, 6'd59, 6'd23}) begin
            n_fail++;
            $display("FAIL btn_59_23_boundary: got %b/%0d/%0d expected 11100/59/23",
                     {load, busy, gnt_butoane, gnt_uart, err_range}, min_out, h_out);
        end
        tick_1hz = 1; cycle(); tick_1hz = 0;
        req_butoane = 0; cycle();
    endtask

    task automatic test_hold();
        int g;
        min_butoane = 6'd1; h_butoane = 6'd1; req_butoane = 1; g = 0;
        for (int i = 0; i < 40; i++) begin
            tick_1hz = (i == 10); cycle(); g += int'(gnt_butoane);
        end
        tick_1hz = 0;
        n_checks++;
        if (g != 1 || load !== 1'b0) begin
            n_fail++;
            $display("FAIL held_level_one_grant: got grants=%0d load=%b expected 1/0", g, load);
        end
        req_butoane = 0; cycle(); req_butoane = 1; g = 0;
        for (int i = 0; i < 10; i++) begin
            tick_1hz = (i == 5); cycle(); g += int'(gnt_butoane);
        end
        tick_1hz = 0;
        n_checks++;
        if (g != 1) begin
            n_fail++;
            $display("FAIL reraise_second_grant: got grants=%0d expected 1", g);
        end
        req_butoane = 0; cycle();
    endtask

    task automatic test_timeout();
        int hl, ne;
        min_uart = 6'd7; h_uart = 6'd8; req_uart = 1; hl = 0; ne = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(); hl += int'(load); ne += int'(err_range);
        end
        n_checks++;
        if (hl != TT || ne != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tick_timeout: got load_cycles=%0d errs=%0d busy=%b expected %0d/1/0", hl, ne, busy, TT);
        end
        req_uart = 0; cycle();
    endtask

    task automatic test_reset_mid_load();
        int g;
        min_butoane = 6'd5; h_butoane = 6'd6; req_butoane = 1;
        cycle(); cycle(); cycle(); cycle();
        n_checks++;
        if (load !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_load_entry: got load=%b expected 1", load);
        end
        req_uart = 1; cycle();
        req_uart = 0; rst = 1; cycle();
        n_checks++;
        if ({load, busy, gnt_butoane, gnt_uart, err_range, min_out, h_out} !== 17'd0) begin
            n_fail++;
            $display("FAIL mid_load_reset: got %h expected 0",
                     {load, busy, gnt_butoane, gnt_uart, err_range, min_out, h_out});
        end
        rst = 0; req_butoane = 0; g = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(); g += int'(gnt_butoane) + int'(gnt_uart) + int'(load);
        end
        n_checks++;
        if (g != 0) begin
            n_fail++;
            $display("FAIL no_grant_after_reset: got activity=%0d expected 0", g);
        end
        min_uart = 6'd11; h_uart = 6'd9; req_uart = 1;
        cycle(); cycle();
        n_checks++;
        if ({load, busy, gnt_butoane, gnt_uart, err_range, min_out, h_out} !== {5'b11010, 6'd11, 6'd9}) begin
            n_fail++;
            $display("FAIL post_reset_new_edge: got %b/%0d/%0d expected 11010/11/9",
                     {load, busy, gnt_butoane, gnt_uart, err_range}, min_out, h_out);
        end
        tick_1hz = 1; cycle(); tick_1hz = 0;
        req_uart = 0; cycle();
    endtask

    task automatic test_random();
        logic [16:0] exp_v, got_v;
        int tick_div;
        for (int i = 0; i < 4000; i++) begin
            tick_div = (i >= 2000 && i < 3000) ? 40 : 6;
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 7) == 0) req_butoane = ~req_butoane;
            if ($urandom_range(0, 7) == 0) req_uart = ~req_uart;
            min_butoane = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 59));
            h_butoane   = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 23));
            min_uart    = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 59));
            h_uart      = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 23));
            tick_1hz = ($urandom_range(1, tick_div) == 1);
            cycle();
            exp_v = {m_load, m_load, m_gb, m_gu, m_err, 6'(m_min), 6'(m_h)};
            got_v = {load, busy, gnt_butoane, gnt_uart, err_range, min_out, h_out};
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL random[%0d]: got %b expected %b", i, got_v, exp_v);
            end
        end
        rst = 0; tick_1hz = 0;
    endtask

    initial begin
        test_reset();
        test_button_load();
        test_both();
        test_range_err();
        test_hold();
        test_timeout();
        test_reset_mid_load();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
